// File: rtl/decoder_pipe_if.sv
// decoder_pipe_if: instruction-in / decoded-fields-out handshake bundle.
interface decoder_pipe_if #(
  parameter int INST_WIDTH = 6,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  localparam int BW = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;
  logic [BW-1:0]         bus;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            ctrl_flags;
  logic [ADDR_WIDTH-1:0] Rd;
  logic [ADDR_WIDTH-1:0] Rs;
  logic [ADDR_WIDTH-1:0] Rt;
  logic [DATA_WIDTH-1:0] imm;
  logic                  illegal;
  logic                  waiting;
  modport master (
    output bus, in_valid, out_ready,
    input  in_ready, out_valid, ctrl_flags, Rd, Rs, Rt, imm, illegal, waiting
  );
  modport slave (
    input  bus, in_valid, out_ready,
    output in_ready, out_valid, ctrl_flags, Rd, Rs, Rt, imm, illegal, waiting
  );
endinterface

// File: rtl/decoder_pipe.sv
// decoder_pipe: single-stage instruction decoder with debounced switch-wait states.
module decoder_pipe #(
  parameter int INST_WIDTH = 6,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEBOUNCE   = 4
) (
  input logic           clk,
  input logic           n_reset,
  input logic           SW8,
  decoder_pipe_if.slave dp
);
  localparam int BW = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE);

  typedef enum logic [1:0] {RUN, WAIT_HI, WAIT_LO} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sync1_q, sync2_q;
  logic                  out_valid_q, out_valid_d;
  logic                  illegal_q, illegal_d;
  logic [7:0]            flags_q, flags_d, flags_dec;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, rs_q, rs_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [INST_WIDTH-1:0] opcode;
  logic                  legal, is_wait, in_rdy, xfer, sw_match;

  assign opcode   = dp.bus[BW-1 -: INST_WIDTH];
  assign legal    = (opcode >> 3) == '0;
  assign is_wait  = legal && opcode[2:1] == 2'b11;
  assign in_rdy   = state_q == RUN && (!out_valid_q || dp.out_ready);
  assign xfer     = dp.in_valid && in_rdy;
  assign sw_match = sync2_q == (state_q == WAIT_HI);

  always_comb begin
    flags_dec = 8'h00;
    if (legal)
      case (opcode[2:0])
        3'd0:    flags_dec = 8'h01;
        3'd1:    flags_dec = 8'h05;
        3'd2:    flags_dec = 8'h03;
        3'd3:    flags_dec = 8'h0B;
        3'd4:    flags_dec = 8'h20;
        3'd5:    flags_dec = 8'h11;
        default: flags_dec = 8'h00;
      endcase
  end

  // A pending output keeps draining through every state, including the waits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    out_valid_d = out_valid_q && !dp.out_ready;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    imm_d       = imm_q;
    if (state_q == RUN) begin
      if (xfer && is_wait)
        state_d = opcode[0] ? WAIT_LO : WAIT_HI;
      if (xfer && !is_wait) begin
        out_valid_d = 1'b1;
        flags_d     = flags_dec;
        illegal_d   = !legal;
        rd_d        = dp.bus[2*ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
        rs_d        = dp.bus[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
        imm_d       = dp.bus[DATA_WIDTH-1:0];
      end
    end else if (cnt_q == DB)
      state_d = RUN;
    else
      cnt_d = sw_match ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      flags_q     <= 8'h00;
      illegal_q   <= 1'b0;
      rd_q        <= '0;
      rs_q        <= '0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= SW8;
      sync2_q     <= sync1_q;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      imm_q       <= imm_d;
    end
  end

  assign dp.in_ready   = in_rdy;
  assign dp.out_valid  = out_valid_q;
  assign dp.ctrl_flags = flags_q;
  assign dp.illegal    = illegal_q;
  assign dp.Rd         = rd_q;
  assign dp.Rs         = rs_q;
  assign dp.Rt         = imm_q[ADDR_WIDTH-1:0];
  assign dp.imm        = imm_q;
  assign dp.waiting    = state_q != RUN;
endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: scoreboard bench with a table-driven decode model and randomized traffic.
module tb_decoder_pipe;
  localparam int IW = 6, AW = 5, DW = 8, DB = 4;
  localparam int BW = IW + 2 * AW + DW;

  typedef struct packed {
    logic [7:0]    flags;
    logic          ill;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] imm;
  } exp_t;

  logic clk = 1'b0, n_reset = 1'b0, SW8 = 1'b0;
  logic rnd_mode = 1'b0, man_ready = 1'b1, rnd_ready = 1'b1;
  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  decoder_pipe_if #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dif ();

  decoder_pipe #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEBOUNCE(DB)) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .SW8    (SW8),
    .dp     (dif)
  );

  assign dif.out_ready = rnd_mode ? rnd_ready : man_ready;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_of(input logic [BW-1:0] w);
    return int'(w >> (BW - IW));
  endfunction

  // Flag values listed per opcode; anything past 7 is illegal with no flags.
  function automatic exp_t model(input logic [BW-1:0] w);
    int   flag_tab[8] = '{8'h01, 8'h05, 8'h03, 8'h0B, 8'h20, 8'h11, 8'h00, 8'h00};
    int   op = op_of(w);
    exp_t e;
    e.ill   = op > 7;
    e.flags = 8'(op > 7 ? 0 : flag_tab[op]);
    e.rd    = AW'((int'(w) >> (AW + DW)) % (1 << AW));
    e.rs    = AW'((int'(w) >> DW) % (1 << AW));
    e.imm   = DW'(int'(w) % (1 << DW));
    e.rt    = AW'(int'(w) % (1 << AW));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (n_reset && dif.out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: out_valid=1, expected no output at %0t", $time);
      end else begin
        e = sb[0];
        check("flags", dif.ctrl_flags, e.flags);
        check("illegal", dif.illegal, e.ill);
        check("Rd", dif.Rd, e.rd);
        check("Rs", dif.Rs, e.rs);
        check("Rt", dif.Rt, e.rt);
        check("imm", dif.imm, e.imm);
        if (dif.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [BW-1:0] w, output int waits);
    int op = op_of(w);
    waits = 0;
    dif.bus = w;
    dif.in_valid = 1'b1;
    @(negedge clk);
    while (!dif.in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!dif.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", waits);
    end else if (op != 6 && op != 7) sb.push_back(model(w));
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_release(input int limit, output int n);
    n = 0;
    while (dif.waiting && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int w, n, r, op;
    logic [BW-1:0] word;
    dif.bus = '0;
    dif.in_valid = 1'b0;
    #3;
    check("rst_out_valid", dif.out_valid, 0);
    check("rst_flags", dif.ctrl_flags, 0);
    check("rst_fields", {dif.Rd, dif.Rs, dif.Rt, dif.imm}, 0);
    check("rst_illegal", dif.illegal, 0);
    check("rst_waiting", dif.waiting, 0);
    #9 n_reset = 1'b1;
    #1 check("rst_in_ready", dif.in_ready, 1);
    @(posedge clk);
    #1;
    send(24'h082105, w);
    check("addi_latency", dif.out_valid, 1);
    send(24'h004304, w);
    check("add_latency", dif.out_valid, 1);
    send(24'h044304, w);
    check("sub_no_bubble", dif.out_valid, 1);
    check("sub_accept_wait", w, 0);
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    send(24'h082105, w);
    check("bp_valid", dif.out_valid, 1);
    dif.bus = 24'h004304;
    dif.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", dif.in_ready, 0);
      check("bp_held_valid", dif.out_valid, 1);
    end
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    send(24'h004304, w);
    check("bp_accept_wait", w, 0);
    SW8 = 1'b0;
    send(24'h180000, w);
    check("waith_waiting", dif.waiting, 1);
    check("waith_in_ready", dif.in_ready, 0);
    SW8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 SW8 = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 check("glitch_hold", dif.waiting, 1);
    end
    SW8 = 1'b1;
    wait_release(50, n);
    check("release_cycles", n, 2 + DB + 1);
    check("release_in_ready", dif.in_ready, 1);
    send(24'hFC0000, w);
    check("illegal_flag", dif.illegal, 1);
    check("illegal_flags", dif.ctrl_flags, 0);
    send(24'h1C0000, w);
    repeat (3) @(posedge clk);
    #1 check("waitl_waiting", dif.waiting, 1);
    #1 n_reset = 1'b0;
    #1;
    check("rstwait_waiting", dif.waiting, 0);
    check("rstwait_out_valid", dif.out_valid, 0);
    check("rstwait_in_ready", dif.in_ready, 1);
    sb.delete();
    #2 n_reset = 1'b1;
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    send(24'h0C6A3F, w);
    check("pend_valid", dif.out_valid, 1);
    n_reset = 1'b0;
    #1;
    check("rstpend_out_valid", dif.out_valid, 0);
    check("rstpend_flags", dif.ctrl_flags, 0);
    sb.delete();
    #2 n_reset = 1'b1;
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      op = r < 12 ? int'($urandom_range(0, 5)) : r < 16 ? int'($urandom_range(8, 63)) :
           r < 18 ? 6 + (r % 2) : int'($urandom_range(0, 5));
      word = BW'($urandom);
      word[BW-1 -: IW] = IW'(op);
      send(word, w);
      if (op == 6 || op == 7) begin
        check("rnd_wait_entry", dif.waiting, 1);
        SW8 = (op == 6);
        wait_release(40, n);
        check("rnd_wait_release", dif.waiting, 0);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rnd_mode = 1'b0;
    man_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter INST_WIDTH, default 6, opcode field width.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width.
REQ-003 Parameter DATA_WIDTH, default 8, immediate field width; SHALL be >= ADDR_WIDTH.
REQ-004 Parameter DEBOUNCE, default 4, consecutive synchronised switch samples required to release a wait; SHALL be >= 1.
REQ-005 Port clk  input  1  single clock, all state on rising edge.
REQ-006 Port n_reset  input  1  reset, asynchronous, active-low.
REQ-007 Port bus  input  INST_WIDTH+2*ADDR_WIDTH+DATA_WIDTH  instruction word {opcode, Rd, Rs, imm}, opcode in MSBs.
REQ-008 Port in_valid  input  1  bus holds a valid instruction.
REQ-009 Port in_ready  output  1  block accepts bus this cycle; transfer = in_valid & in_ready.
REQ-010 Port SW8  input  1  asynchronous user switch.
REQ-011 Port out_valid  output  1  decoded fields valid.
REQ-012 Port out_ready  input  1  consumer accepts output; transfer = out_valid & out_ready.
REQ-013 Port ctrl_flags  output  8  control flags (REQ-019).
REQ-014 Port Rd, Rs, Rt  output  ADDR_WIDTH each  destination, source, second source (Rt = imm[ADDR_WIDTH-1:0]).
REQ-015 Port imm  output  DATA_WIDTH  immediate field.
REQ-016 Port illegal  output  1  decoded opcode undefined.
REQ-017 Port waiting  output  1  high while in a wait state.

Function
REQ-018 Opcodes: 0 ADD, 1 SUB, 2 ADDI, 3 MULI, 4 BRANCH, 5 LOADSW, 6 WAITH, 7 WAITL; all others illegal.
REQ-019 ctrl_flags bits: [0] reg_write, [1] alu_imm, [2] alu_sub, [3] alu_mul, [4] sel_sw, [5] branch, [7:6] always 0; values ADD 0x01, SUB 0x05, ADDI 0x03, MULI 0x0B, BRANCH 0x20, LOADSW 0x11, illegal 0x00 with illegal=1.
REQ-020 Non-wait instruction: fields and flags SHALL be registered; out_valid rises the cycle after the input transfer (latency 1).
REQ-021 Output register SHALL hold all outputs stable while out_valid & !out_ready.
REQ-022 in_ready = (state==RUN) & (!out_valid | out_ready); back-to-back transfers at 1 per cycle SHALL be sustained.
REQ-023 SW8 SHALL pass through a 2-flop synchroniser before use; debounce counter counts consecutive cycles synchronised SW8 equals the target level, clears on mismatch.
REQ-024 FSM states RUN, WAIT_HI, WAIT_LO.
REQ-025 RUN: accepting WAITH -> WAIT_HI, WAITL -> WAIT_LO; counter cleared on entry; no output produced for wait instructions.
REQ-026 WAIT_HI/WAIT_LO: in_ready=0, waiting=1; when counter reaches DEBOUNCE -> RUN next cycle, counter cleared.
REQ-027 An output already pending when a wait is entered SHALL remain valid and drain normally via out_ready.
REQ-028 Counter SHALL saturate at DEBOUNCE, never wrap.
REQ-029 Illegal opcode SHALL transfer and produce an output with illegal=1, Rd/Rs/Rt/imm decoded as normal.
REQ-030 in_valid while in_ready=0 SHALL be ignored (no state change).

Reset
REQ-031 n_reset low SHALL asynchronously force: state RUN, out_valid 0, ctrl_flags 0x00, Rd/Rs/Rt/imm 0, illegal 0, waiting 0, counter 0, synchroniser flops 0.
REQ-032 Reset mid-wait or with pending output SHALL discard both; first transfer possible on the first rising edge after release (in_ready=1 combinationally once n_reset high).

Verification
REQ-033 ADDI: bus 0x082105, in_valid 1 cycle, out_ready 1 -> next cycle out_valid 1, ctrl_flags 0x03, Rd 1, Rs 1, imm 0x05.
REQ-034 ADD then SUB back-to-back (0x004304, 0x044304) -> two consecutive outputs 0x01 then 0x05, Rd 2, Rs 3, Rt 4, no bubble.
REQ-035 Backpressure: out_ready 0 for 3 cycles after ADDI -> outputs held, in_ready 0, second instruction accepted the cycle out_ready returns 1.
REQ-036 WAITH 0x180000 with SW8 0 -> waiting 1, in_ready 0; SW8 1 for 3 cycles then 0 -> no release; SW8 1 held -> release after 2 sync + DEBOUNCE(4) cycles, then in_ready 1.
REQ-037 Illegal 0xFC0000 -> ctrl_flags 0x00, illegal 1; n_reset pulse during WAIT_LO -> waiting 0, out_valid 0 immediately.
